add_serial: RTL and testbench

Bit-serial multi-bit adder controller. Accepts two WIDTH-bit operands and a carry-in through a start/ready handshake. Sequences one instance of the team's 1-bit full-adder cell `add` (ports c, a, b, c_out, sum) over WIDTH clock cycles, LSB first, carrying between bits in a flip-flop. It then presents the registered WIDTH-bit sum and final carry with a one-cycle done pulse. It is the sequencing layer above the combinational `add` cell, for area-constrained datapaths that trade latency for a single adder cell.

---
 rtl/add_serial.sv | 121 ++++++++++++
 tb/tb_add_serial.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial.sv
// Bit-serial WIDTH-bit adder built from a single 1-bit full-adder cell.
// Latency: done pulses WIDTH cycles after the accepting edge; start is only taken in IDLE and is never queued.

// One-bit full-adder cell, purely combinational.
module add (
  input  logic c,
  input  logic a,
  input  logic b,
  output logic c_out,
  output logic sum
);

  assign sum   = a ^ b ^ c;
  assign c_out = (a & b) | (c & (a ^ b));

endmodule

module add_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             cell_sum, cell_cout;

  add u_add (
    .c     (cy),
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_out (cell_cout),
    .sum   (cell_sum)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  if (WIDTH == 1) begin : g_acc_w1
    assign acc_nxt = cell_sum;
  end else begin : g_acc_wn
    assign acc_nxt = {cell_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cy      <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      sum_out <= '0;
      c_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a_in;
            b_sh <= b_in;
            cy   <= c_in;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          cy   <= cell_cout;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
          // Result registers move only on the final bit, so they hold across the next operation.
          if (cnt == LAST) begin
            sum_out <= acc_nxt;
            c_out   <= cell_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_add_serial.sv
// Self-checking bench for add_serial at WIDTH=8 and WIDTH=1 with a queue scoreboard.
module tb_add_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       c8 = 1'b0;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;

  logic start1 = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic ready1, busy1, done1, cout1;
  logic sum1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  add_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .c_in(c8),
    .ready(ready8), .busy(busy8), .done(done8), .sum_out(sum8), .c_out(cout8)
  );

  add_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .c_in(c1),
    .ready(ready1), .busy(busy1), .done(done1), .sum_out(sum1), .c_out(cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [8:0] exp, input string name);
    int n;
    logic [8:0] e;
    start8 = 1'b1; a8 = a; b8 = b; c8 = c;
    q8.push_back(exp);
    tick();
    start8 = 1'b0; a8 = ~a; b8 = 8'($urandom); c8 = ~c;
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      n_tests++;
      if (busy8 !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy: got %b want 1 at edge %0d", name, busy8, n);
      end
      tick();
      n++;
    end
    n_tests++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL %s latency: done after %0d edges want 8", name, n);
    end
    e = q8.pop_front();
    n_tests++;
    if ({cout8, sum8} !== e) begin
      n_fail++;
      $display("FAIL %s result: got c=%b sum=%h want c=%b sum=%h", name, cout8, sum8, e[8], e[7:0]);
    end
    tick();
    n_tests++;
    if (ready8 !== 1'b1 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_after: got ready=%b done=%b want 1/0", name, ready8, done8);
    end
  endtask

  task automatic run_op1(input logic a, input logic b, input logic c);
    int n;
    logic [1:0] e;
    start1 = 1'b1; a1 = a; b1 = b; c1 = c;
    q1.push_back(2'(a) + 2'(b) + 2'(c));
    tick();
    start1 = 1'b0; a1 = ~a; b1 = ~b; c1 = ~c;
    n = 0;
    while (done1 !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL w1 latency: done after %0d edges want 1", n);
    end
    e = q1.pop_front();
    n_tests++;
    if ({cout1, sum1} !== e) begin
      n_fail++;
      $display("FAIL w1 result: got %b%b want %b", cout1, sum1, e);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got r/b/d=%b%b%b want 100", ready8, busy8, done8);
    end
    n_tests++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_result: got c=%b sum=%h want 0/00", cout8, sum8);
    end
    n_tests++;
    if (ready1 !== 1'b1 || sum1 !== 1'b0 || cout1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_w1: got ready=%b sum=%b c=%b want 1/0/0", ready1, sum1, cout1);
    end
    start8 = 1'b1;
    tick();
    rst = 1'b0;
    start8 = 1'b0;
    tick();
    n_tests++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL start_during_reset: got ready=%b busy=%b want 1/0", ready8, busy8);
    end
  endtask

  task automatic test_basic();
    run_op8(8'h0F, 8'h33, 1'b0, 9'h042, "basic");
  endtask

  task automatic test_carry();
    run_op8(8'hFF, 8'h01, 1'b0, 9'h100, "carry_ff_01");
    run_op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "carry_ff_ff_1");
    run_op8(8'h00, 8'h00, 1'b1, 9'h001, "carry_00_00_1");
  endtask

  task automatic test_back_to_back();
    logic [8:0] held;
    held = {cout8, sum8};
    start8 = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int ph;
      ph = t % 10;
      n_tests++;
      if (ready8 !== (ph == 0) || busy8 !== (ph >= 1 && ph <= 8) || done8 !== (ph == 9)) begin
        n_fail++;
        $display("FAIL b2b_state t=%0d: got r/b/d=%b%b%b", t, ready8, busy8, done8);
      end
      if (ph == 9) held = q8.pop_front();
      n_tests++;
      if ({cout8, sum8} !== held) begin
        n_fail++;
        $display("FAIL b2b_result t=%0d: got %h want %h", t, {cout8, sum8}, held);
      end
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      if (ph == 0) q8.push_back(9'(a8) + 9'(b8) + 9'(c8));
      if (t == 39) start8 = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    run_op8(8'h55, 8'h0A, 1'b0, 9'h05F, "pre_abort");
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got r/b/d=%b%b%b want 100", ready8, busy8, done8);
    end
    n_tests++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_result: got c=%b sum=%h want 0/00", cout8, sum8);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (done8 !== 1'b0 || sum8 !== 8'h00) begin
        n_fail++;
        $display("FAIL abort_no_done cycle %0d: got done=%b sum=%h", i, done8, sum8);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      logic c;
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      run_op8(a, b, c, 9'(a) + 9'(b) + 9'(c), "rand8");
    end
    for (int i = 0; i < 1000; i++) begin
      run_op1(1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
